priority_encoder8to3: RTL and testbench

Registered 8-to-3 priority encoder with sticky pending requests and an acknowledge handshake. It is the encode-side counterpart of the team's 3-to-8 decoders. It captures rising edges on eight request lines into a pending register. It presents the index of the highest-priority pending request on `Y` with a valid flag, and clears that request when the consumer acknowledges it. It sits between event sources (buttons, status strobes) and a consumer that serves one index at a time, for example a decoder-driven select stage.

---
 rtl/priority_encoder8to3.sv | 47 ++++
 tb/tb_priority_encoder8to3.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/priority_encoder8to3.sv
// priority_encoder8to3: registered 8-to-3 priority encoder with sticky edge-captured requests and ack.
// Define PRIO_ENC_OVF_EN to add the ovf pulse flagging a rise that merges into an already-pending bit.
module priority_encoder8to3 #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic       OE,
    input  logic       ack,
    output logic [2:0] Y,
    output logic       V,
    output logic [7:0] pend
`ifdef PRIO_ENC_OVF_EN
    ,
    output logic       ovf
`endif
);
    logic [7:0] a_q;
    logic [7:0] set;
    logic [7:0] clr;
    assign set = A & ~a_q & {8{OE}};
    assign V = OE & |pend;
    assign clr = (ack & V) ? 8'b1 << Y : 8'h00;
    // Later matches overwrite earlier ones, so scan order picks the winner.
    always_comb begin
        Y = 3'd0;
        for (int i = 0; i < 8; i++)
            if (HIGH_FIRST ? pend[i] : pend[7-i])
                Y = HIGH_FIRST ? 3'(i) : 3'(7 - i);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pend <= 8'h00;
            a_q <= 8'h00;
        end else begin
            pend <= (pend & ~clr) | set;
            a_q <= A;
        end
`ifdef PRIO_ENC_OVF_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            ovf <= 1'b0;
        else
            ovf <= |(set & pend & ~clr);
`endif
endmodule

// File: tb/tb_priority_encoder8to3.sv
// tb_priority_encoder8to3: directed vectors feed a scoreboard queue; a monitor pops and compares.
module tb_priority_encoder8to3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic oe = 1'b0;
    logic ack = 1'b0;
    logic [7:0] a = 8'h00;
    logic [2:0] y_h, y_l;
    logic v_h, v_l;
    logic [7:0] pend_h, pend_l;
`ifdef PRIO_ENC_OVF_EN
    logic ovf_h, ovf_l;
`endif
    typedef struct {
        bit lo;
        logic [7:0] p;
        logic v;
        logic [2:0] y;
        logic o;
        string nm;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    event mon_now;

    always #5 clk = ~clk;

    priority_encoder8to3 #(.HIGH_FIRST(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .A(a), .OE(oe), .ack(ack),
        .Y(y_h), .V(v_h), .pend(pend_h)
`ifdef PRIO_ENC_OVF_EN
        , .ovf(ovf_h)
`endif
    );
    priority_encoder8to3 #(.HIGH_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .A(a), .OE(oe), .ack(ack),
        .Y(y_l), .V(v_l), .pend(pend_l)
`ifdef PRIO_ENC_OVF_EN
        , .ovf(ovf_l)
`endif
    );

    initial forever begin
        exp_t e;
        logic [7:0] p;
        logic v;
        logic [2:0] y;
        @(negedge clk or mon_now);
        if (q.size() > 0) begin
            e = q.pop_front();
            p = e.lo ? pend_l : pend_h;
            v = e.lo ? v_l : v_h;
            y = e.lo ? y_l : y_h;
            tests++;
            if ({p, v, y} !== {e.p, e.v, e.y}) begin
                fails++;
                $display("FAIL %s: got pend=%h V=%b Y=%0d, want pend=%h V=%b Y=%0d",
                         e.nm, p, v, y, e.p, e.v, e.y);
            end
`ifdef PRIO_ENC_OVF_EN
            tests++;
            if ((e.lo ? ovf_l : ovf_h) !== e.o) begin
                fails++;
                $display("FAIL %s_ovf: got ovf=%b, want %b", e.nm, e.lo ? ovf_l : ovf_h, e.o);
            end
`endif
        end
    end

    task automatic step(input logic [7:0] av, input logic oev, input logic ackv, input bit lo,
                        input logic [7:0] ep, input logic ev, input logic [2:0] ey,
                        input logic eo, input string nm);
        exp_t e;
        a = av;
        oe = oev;
        ack = ackv;
        @(posedge clk);
        #1;
        e = '{lo, ep, ev, ey, eo, nm};
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic check_now(input bit lo, input string nm);
        exp_t e;
        e = '{lo, 8'h00, 1'b0, 3'd0, 1'b0, nm};
        q.push_back(e);
        -> mon_now;
        #1;
    endtask

    initial begin
        step(8'h00, 1, 0, 0, 8'h00, 0, 3'd0, 0, "reset");
        rst_n = 1'b1;
        step(8'h24, 1, 0, 0, 8'h24, 1, 3'd5, 0, "cap_24");
        step(8'h00, 1, 1, 0, 8'h04, 1, 3'd2, 0, "ack_5");
        step(8'h00, 1, 1, 0, 8'h00, 0, 3'd0, 0, "ack_2");
        step(8'h01, 1, 0, 0, 8'h01, 1, 3'd0, 0, "cap_01");
        step(8'h41, 1, 0, 0, 8'h41, 1, 3'd6, 0, "preempt_6");
        step(8'h41, 1, 1, 0, 8'h01, 1, 3'd0, 0, "ack_6");
        step(8'h41, 1, 1, 0, 8'h00, 0, 3'd0, 0, "ack_0");
        step(8'h00, 1, 0, 0, 8'h00, 0, 3'd0, 0, "idle");
        step(8'h08, 1, 0, 0, 8'h08, 1, 3'd3, 0, "cap_08");
        step(8'h00, 1, 0, 0, 8'h08, 1, 3'd3, 0, "hold_08");
        step(8'h08, 1, 1, 0, 8'h08, 1, 3'd3, 0, "set_wins");
        step(8'h00, 1, 0, 0, 8'h08, 1, 3'd3, 0, "hold_08b");
        step(8'h08, 1, 0, 0, 8'h08, 1, 3'd3, 1, "merge_ovf");
        step(8'h08, 1, 0, 0, 8'h08, 1, 3'd3, 0, "ovf_drop");
        step(8'h08, 1, 1, 0, 8'h00, 0, 3'd0, 0, "ack_3");
        step(8'h81, 1, 0, 0, 8'h81, 1, 3'd7, 0, "cap_81");
        step(8'h00, 0, 1, 0, 8'h81, 0, 3'd7, 0, "oe0_ack_ignored");
        step(8'h10, 0, 0, 0, 8'h81, 0, 3'd7, 0, "oe0_rise_lost");
        step(8'h10, 1, 0, 0, 8'h81, 1, 3'd7, 0, "oe1_resume");
        step(8'h00, 1, 1, 0, 8'h01, 1, 3'd0, 0, "ack_7");
        step(8'h00, 1, 1, 0, 8'h00, 0, 3'd0, 0, "ack_0b");
        rst_n = 1'b0;
        step(8'hFF, 1, 0, 0, 8'h00, 0, 3'd0, 0, "hi_rst");
        rst_n = 1'b1;
        step(8'hFF, 1, 0, 0, 8'hFF, 1, 3'd7, 0, "hi_cap_ff");
        for (int k = 1; k <= 8; k++)
            step(8'hFF, 1, 1, 0, 8'(8'hFF >> k), k < 8, k < 8 ? 3'(7 - k) : 3'd0, 0, "hi_drain");
        step(8'hFF, 1, 0, 0, 8'h00, 0, 3'd0, 0, "hi_no_recap");
        rst_n = 1'b0;
        step(8'h00, 1, 0, 0, 8'h00, 0, 3'd0, 0, "rst2");
        rst_n = 1'b1;
        step(8'h3C, 1, 0, 0, 8'h3C, 1, 3'd5, 0, "cap_3c");
        rst_n = 1'b0;
        #1;
        check_now(0, "async_rst");
        a = 8'hFF;
        step(8'hFF, 1, 0, 1, 8'h00, 0, 3'd0, 0, "lo_rst");
        rst_n = 1'b1;
        step(8'hFF, 1, 0, 1, 8'hFF, 1, 3'd0, 0, "lo_cap_ff");
        for (int k = 1; k <= 8; k++)
            step(8'hFF, 1, 1, 1, 8'(8'hFF << k), k < 8, k < 8 ? 3'(k) : 3'd0, 0, "lo_drain");
        step(8'hFF, 1, 0, 1, 8'h00, 0, 3'd0, 0, "lo_no_recap");
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain_queue: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
